debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the D flip-flop stages.
- Takes a raw asynchronous level (switch, button or external pin) and runs it through a 2-flop synchroniser and a counter-based debounce FSM.
- Delivers a clean, glitch-free level `q` suitable as the `d` input of downstream flops.
- Also delivers single-cycle `rise`/`fall` event pulses.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronised samples at the new level required before `q` changes. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 3: width of the stability counter.
- RESET_LEVEL, 0: value of `q` and of both synchroniser flops while in reset.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- en  input  1  debounce enable; 0 freezes the FSM and counter.
- d_in  input  1  raw asynchronous input level.
- q  output  1  debounced, synchronised level; registered.
- rise  output  1  one-cycle pulse when `q` goes 0->1; registered.
- fall  output  1  one-cycle pulse when `q` goes 1->0; registered.
- busy  output  1  high while a level change is being qualified (CHK_HIGH or CHK_LOW).

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-qualification):
  - s1 = s2 = q = RESET_LEVEL; rise = fall = busy = 0; cnt = 0.
  - State = HIGH if RESET_LEVEL=1, else LOW.
  - On release, operation resumes at the next posedge; no pulse is generated by reset or by its release.
- Synchroniser: s1 <= d_in, s2 <= s1 on every posedge, regardless of `en`. The FSM looks only at s2.
- States:
  - LOW (q=0).
  - CHK_HIGH (q=0, busy=1).
  - HIGH (q=1).
  - CHK_LOW (q=1, busy=1).
- Transitions (evaluated at posedge when en=1):
  - LOW, s2=1: if STABLE_CYCLES=1, go to HIGH. Otherwise go to CHK_HIGH with cnt<=1.
  - CHK_HIGH, s2=0: go to LOW with cnt<=0 and no pulse (glitch rejected).
  - CHK_HIGH, s2=1, cnt<STABLE_CYCLES-1: cnt<=cnt+1.
  - CHK_HIGH, s2=1, cnt==STABLE_CYCLES-1: go to HIGH with cnt<=0.
  - HIGH and CHK_LOW are the exact mirror, with s2 polarity inverted.
- Output timing:
  - `q` updates at the same edge as the state change into HIGH or LOW.
  - `rise` is 1 for exactly one cycle after the edge that enters HIGH from CHK_HIGH (or from LOW when STABLE_CYCLES=1).
  - `fall` is the mirror for entry into LOW.
  - `rise` and `fall` are never 1 together.
- Latency: d_in held at the new level from before edge 1 gives `q` and the pulse after edge STABLE_CYCLES+2.
  - 2 edges are synchroniser latency.
  - STABLE_CYCLES edges are the stability window.
  - A pulse of STABLE_CYCLES-1 or fewer sampled cycles never reaches `q`.
- en=0: state, cnt and q hold; rise/fall forced 0 at the next edge; busy reflects the held state.
  - When en returns to 1, counting continues from the held cnt using the current s2.
  - Samples taken while en=0 are not counted and do not abort qualification.
- Counter: saturates by construction (max STABLE_CYCLES-1). No wrap-around is possible for legal parameters.
- Input toggling every cycle: the FSM alternates between LOW and CHK_HIGH (or HIGH and CHK_LOW); q is stable and no pulses occur.

Test Plan (STABLE_CYCLES=4, RESET_LEVEL=0 unless noted):
1. Async reset: rst falls mid-cycle while the block is in CHK_HIGH -> q, rise, fall, busy read 0 before the next posedge. After release with d_in=1 held, q=1 after the 6th edge and rise pulses once.
2. Clean rise: d_in 0->1 before edge 1, held -> busy=1 after edge 3; q=1, rise=1, busy=0 after edge 6; rise=0 after edge 7; fall stays 0 throughout.
3. Glitch rejection: d_in high for exactly 3 sampled cycles, then low -> busy pulses high, q stays 0, rise never asserts. Repeat with 4 cycles -> q=1 after edge 6 with a single rise pulse.
4. Clean fall: from q=1, d_in 1->0 held -> fall=1 and q=0 after edge 6, for one cycle only. Then STABLE_CYCLES=1 build: q follows d_in after edge 3.
5. Enable freeze: en=0 for 5 cycles when cnt=2 in CHK_HIGH -> q and busy held, no pulses. en=1 with d_in still high -> q=1 two edges later.
6. Toggling input: d_in toggles every cycle for 50 cycles -> q constant, rise=fall=0 throughout. RESET_LEVEL=1 build: after reset q=1 with no fall pulse.

Source files
------------

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
//   Conditions a raw asynchronous level (switch, button, external pin) for use
//   as the d input of downstream flops. The level passes through a 2-flop
//   synchroniser. A counter-based FSM then only accepts a new level after it
//   has been seen for STABLE_CYCLES consecutive enabled samples.
//
// Parameters
//   STABLE_CYCLES : consecutive synchronised samples needed to change q
//                   (1 .. 2**CNT_W-1)
//   CNT_W         : stability counter width
//   RESET_LEVEL   : value of q and both synchroniser flops while in reset
//
// Ports
//   clk   in  : clock, all state updates on posedge
//   rst   in  : asynchronous active-low reset
//   en    in  : debounce enable; 0 freezes FSM, counter and q
//   d_in  in  : raw asynchronous input level
//   q     out : debounced level (registered)
//   rise  out : one-cycle pulse when q goes 0->1 (registered)
//   fall  out : one-cycle pulse when q goes 1->0 (registered)
//   busy  out : high while a level change is being qualified (registered)
// ---------------------------------------------------------------------------
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_e;

    // Count value at which the next matching sample completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a one-sample window a new level is accepted without a CHK state.
    localparam bit               SINGLE   = (STABLE_CYCLES == 1);

    logic             s1_q;
    logic             s2_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchroniser; runs regardless of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= RESET_LEVEL;
            s2_q <= RESET_LEVEL;
        end else begin
            s1_q <= d_in;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM with registered q/rise/fall/busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_LEVEL ? ST_HIGH : ST_LOW;
            cnt_q   <= '0;
            q       <= RESET_LEVEL;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // Pulses last one cycle; also forced low while frozen.
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_LOW: begin
                        if (s2_q) begin
                            if (SINGLE) begin
                                state_q <= ST_HIGH;
                                q       <= 1'b1;
                                rise    <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                state_q <= ST_CHK_HIGH;
                                cnt_q   <= CNT_ONE;
                                busy    <= 1'b1;
                            end
                        end
                    end
                    ST_CHK_HIGH: begin
                        if (!s2_q) begin
                            // Glitch rejected: back to LOW, no pulse.
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                            q       <= 1'b1;
                            rise    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!s2_q) begin
                            if (SINGLE) begin
                                state_q <= ST_LOW;
                                q       <= 1'b0;
                                fall    <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                state_q <= ST_CHK_LOW;
                                cnt_q   <= CNT_ONE;
                                busy    <= 1'b1;
                            end
                        end
                    end
                    ST_CHK_LOW: begin
                        if (s2_q) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                            q       <= 1'b0;
                            fall    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                        q       <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync
//   Directed bench for debounce_sync. Three instances share clk/rst/en:
//     u_dut : STABLE_CYCLES=4, RESET_LEVEL=0 (main table and sequences)
//     u_one : STABLE_CYCLES=1
//     u_rl1 : RESET_LEVEL=1
//   Inputs change 1ns after a posedge; outputs are checked at the same point,
//   i.e. each vector's expected outputs are those just after its edge.
// ---------------------------------------------------------------------------
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic d0  = 1'b0;
    logic d1  = 1'b0;
    logic d2  = 1'b1;

    logic q0, rise0, fall0, busy0;
    logic q1, rise1, fall1, busy1;
    logic q2, rise2, fall2, busy2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       d;
        logic       en;
        logic [3:0] exp;  // {q, rise, fall, busy}
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    debounce_sync #(.STABLE_CYCLES(4), .CNT_W(3), .RESET_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .d_in(d0),
        .q(q0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    debounce_sync #(.STABLE_CYCLES(1), .CNT_W(3), .RESET_LEVEL(1'b0)) u_one (
        .clk(clk), .rst(rst), .en(en), .d_in(d1),
        .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    debounce_sync #(.STABLE_CYCLES(4), .CNT_W(3), .RESET_LEVEL(1'b1)) u_rl1 (
        .clk(clk), .rst(rst), .en(en), .d_in(d2),
        .q(q2), .rise(rise2), .fall(fall2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input logic d, input logic e, input logic [3:0] exp);
        vec_t v;
        v.d   = d;
        v.en  = e;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        int rise_cnt;

        // ---------------- reset state ----------------
        step();
        step();
        chk("reset_main", {q0, rise0, fall0, busy0}, 4'b0000);
        chk("reset_one",  {q1, rise1, fall1, busy1}, 4'b0000);
        chk("reset_rl1",  {q2, rise2, fall2, busy2}, 4'b1000);
        rst = 1'b1;

        // RESET_LEVEL=1: stays high after release with no fall pulse.
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rl1_hold", {q2, rise2, fall2, busy2}, 4'b1000);
            chk("idle_main", {q0, rise0, fall0, busy0}, 4'b0000);
        end
        // RESET_LEVEL=1 instance: clean fall after edge 6.
        d2 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k <= 2)      chk("rl1_fall", {q2, rise2, fall2, busy2}, 4'b1000);
            else if (k <= 5) chk("rl1_fall", {q2, rise2, fall2, busy2}, 4'b1001);
            else if (k == 6) chk("rl1_fall", {q2, rise2, fall2, busy2}, 4'b0010);
            else             chk("rl1_fall", {q2, rise2, fall2, busy2}, 4'b0000);
        end

        // ---------------- main table ----------------
        // clean rise
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001); add(1, 1, 4'b0001);
        add(1, 1, 4'b0001); add(1, 1, 4'b1100); add(1, 1, 4'b1000); add(1, 1, 4'b1000);
        // clean fall
        add(0, 1, 4'b1000); add(0, 1, 4'b1000); add(0, 1, 4'b1001); add(0, 1, 4'b1001);
        add(0, 1, 4'b1001); add(0, 1, 4'b0010); add(0, 1, 4'b0000); add(0, 1, 4'b0000);
        // 3-sample glitch rejected
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001); add(0, 1, 4'b0001);
        add(0, 1, 4'b0001); add(0, 1, 4'b0000); add(0, 1, 4'b0000); add(0, 1, 4'b0000);
        // 4-sample pulse accepted, then qualified back low
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001); add(1, 1, 4'b0001);
        add(0, 1, 4'b0001); add(0, 1, 4'b1100); add(0, 1, 4'b1001); add(0, 1, 4'b1001);
        add(0, 1, 4'b1001); add(0, 1, 4'b0010); add(0, 1, 4'b0000); add(0, 1, 4'b0000);
        // enable freeze at cnt=2 in CHK_HIGH
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001); add(1, 1, 4'b0001);
        add(1, 0, 4'b0001); add(1, 0, 4'b0001); add(1, 0, 4'b0001); add(1, 0, 4'b0001);
        add(1, 0, 4'b0001); add(1, 1, 4'b0001); add(1, 1, 4'b1100); add(1, 1, 4'b1000);

        for (int i = 0; i < vecs.size(); i++) begin
            d0 = vecs[i].d;
            en = vecs[i].en;
            step();
            chk($sformatf("vec[%0d]", i), {q0, rise0, fall0, busy0}, vecs[i].exp);
        end
        en = 1'b1;

        // ---------------- toggling input from q=1 ----------------
        for (int i = 0; i < 50; i++) begin
            d0 = ~d0;
            step();
            chk($sformatf("toggle[%0d]", i), {1'b0, q0, rise0, fall0}, 4'b0100);
        end

        // ---------------- async reset mid-qualification ----------------
        d0  = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        chk("pre_rst_busy", {q0, rise0, fall0, busy0}, 4'b0001);
        #3 rst = 1'b0;
        #1;
        chk("async_rst", {q0, rise0, fall0, busy0}, 4'b0000);
        #1 rst = 1'b1;
        rise_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (rise0) rise_cnt++;
            if (k == 5)      chk("post_rst_e5", {q0, rise0, fall0, busy0}, 4'b0001);
            else if (k == 6) chk("post_rst_e6", {q0, rise0, fall0, busy0}, 4'b1100);
            else if (k == 9) chk("post_rst_e9", {q0, rise0, fall0, busy0}, 4'b1000);
        end
        chk("post_rst_rises", 4'(rise_cnt), 4'd1);

        // ---------------- STABLE_CYCLES=1: q follows after edge 3 ----------------
        d1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k <= 2)      chk("one_rise", {q1, rise1, fall1, busy1}, 4'b0000);
            else if (k == 3) chk("one_rise", {q1, rise1, fall1, busy1}, 4'b1100);
            else             chk("one_rise", {q1, rise1, fall1, busy1}, 4'b1000);
        end
        d1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k <= 2)      chk("one_fall", {q1, rise1, fall1, busy1}, 4'b1000);
            else if (k == 3) chk("one_fall", {q1, rise1, fall1, busy1}, 4'b0010);
            else             chk("one_fall", {q1, rise1, fall1, busy1}, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
